// File: rtl/highlight_cursor_ctrl.sv
// rtl/highlight_cursor_ctrl.sv - cursor/selection sequencer for the product highlight overlay
// Button pulses move a cursor; the highlight register only reloads on FrameStart.
module highlight_cursor_ctrl #(
  parameter int NUM_ITEMS      = 12,
  parameter int BLINK_FRAMES   = 8,
  parameter int CONFIRM_FRAMES = 48,
  parameter int IDLE_FRAMES    = 600,
  parameter int FCNT_WIDTH     = 10
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 FrameStart,
  input  logic                 BtnNext,
  input  logic                 BtnPrev,
  input  logic                 BtnSelect,
  output logic [NUM_ITEMS-1:0] HighlightedProductList,
  output logic                 SelectPulse,
  output logic [3:0]           SelectedIndex,
  output logic                 Busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BROWSE  = 2'd1,
    S_CONFIRM = 2'd2
  } state_e;

  localparam logic [3:0]            LAST      = 4'(NUM_ITEMS - 1);
  localparam logic [FCNT_WIDTH-1:0] ONE       = FCNT_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0] IDLE_END  = FCNT_WIDTH'(IDLE_FRAMES);
  localparam logic [FCNT_WIDTH-1:0] CONF_END  = FCNT_WIDTH'(CONFIRM_FRAMES);
  localparam logic [FCNT_WIDTH-1:0] BLINK_END = FCNT_WIDTH'(BLINK_FRAMES - 1);
  localparam logic [NUM_ITEMS-1:0]  BIT0      = {{(NUM_ITEMS-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [3:0]            cursor_q, cursor_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [FCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                  blink_q, blink_d;
  logic [NUM_ITEMS-1:0]  list_q, list_d;
  logic                  pulse_q, pulse_d;
  logic [3:0]            idx_q, idx_d;

  logic [NUM_ITEMS-1:0]  onehot;
  logic [NUM_ITEMS-1:0]  disp;
  logic [FCNT_WIDTH-1:0] fcnt_sat;
  logic                  any_btn;

  assign onehot   = BIT0 << cursor_q;
  assign fcnt_sat = (fcnt_q == '1) ? fcnt_q : fcnt_q + ONE;
  assign any_btn  = BtnNext | BtnPrev | BtnSelect;

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    pulse_d  = 1'b0;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        // The wake-up press only changes state; it never moves or selects.
        if (any_btn) begin
          state_d = S_BROWSE;
          fcnt_d  = '0;
        end
      end
      S_BROWSE: begin
        if (BtnSelect) begin
          state_d = S_CONFIRM;
          fcnt_d  = '0;
          bcnt_d  = '0;
          blink_d = 1'b0;
          pulse_d = 1'b1;
          idx_d   = cursor_q;
        end else if (BtnNext || BtnPrev) begin
          fcnt_d = '0;
          if (BtnNext && !BtnPrev) begin
            cursor_d = (cursor_q == LAST) ? 4'd0 : cursor_q + 4'd1;
          end else if (BtnPrev && !BtnNext) begin
            cursor_d = (cursor_q == 4'd0) ? LAST : cursor_q - 4'd1;
          end
        end else if (FrameStart) begin
          fcnt_d = fcnt_sat;
          if (fcnt_sat == IDLE_END) state_d = S_IDLE;
        end
      end
      S_CONFIRM: begin
        if (FrameStart) begin
          fcnt_d = fcnt_sat;
          if (bcnt_q == BLINK_END) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + ONE;
          end
          if (fcnt_sat == CONF_END) begin
            state_d = S_BROWSE;
            fcnt_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    disp = '0;
    case (state_q)
      S_BROWSE:  disp = onehot;
      S_CONFIRM: disp = blink_q ? '0 : onehot;
      default:   disp = '0;
    endcase
    list_d = FrameStart ? disp : list_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cursor_q <= '0;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      list_q   <= '0;
      pulse_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      list_q   <= list_d;
      pulse_q  <= pulse_d;
      idx_q    <= idx_d;
    end
  end

  assign HighlightedProductList = list_q;
  assign SelectPulse            = pulse_q;
  assign SelectedIndex          = idx_q;
  assign Busy                   = (state_q == S_CONFIRM);

endmodule
